// File: rtl/seq_eq_pkg.sv
// Shared state encoding and equality-flag constants for the sequence equality checker.
package seq_eq_pkg;

  typedef enum logic [1:0] {
    PROG   = 2'd0,
    IDLE   = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } state_e;

  localparam int unsigned EQ_TRUE  = 1;
  localparam int unsigned EQ_FALSE = 0;

endpackage

// File: rtl/symbol_compare.sv
// Combinational symbol comparator producing a zero-extended equality flag.
module symbol_compare
  import seq_eq_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned OUT_W = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [OUT_W-1:0] eq
);

  always_comb begin
    eq = (a == b) ? OUT_W'(EQ_TRUE) : OUT_W'(EQ_FALSE);
  end

endmodule

// File: rtl/sequence_equality_checker.sv
// Sequential code checker: programs a secret of DEPTH symbols, checks guessed
// sequences against it, counts matches and locks out after MAX_TRIES misses.
module sequence_equality_checker
  import seq_eq_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned OUT_W     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             prog_valid,
  input  logic [WIDTH-1:0]                 prog_data,
  input  logic                             guess_valid,
  input  logic [WIDTH-1:0]                 guess_data,
  input  logic                             clear,
  output logic [OUT_W-1:0]                 sym_equal,
  output logic [$clog2(DEPTH+1)-1:0]       match_count,
  output logic                             result_valid,
  output logic                             result_match,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic                             locked
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   secret_q [DEPTH];
  logic [WIDTH-1:0]   secret_d [DEPTH];
  logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               miss_q, miss_d;
  logic [OUT_W-1:0]   sym_equal_q, sym_equal_d;
  logic [CNT_W-1:0]   match_count_q, match_count_d;
  logic               result_valid_q, result_valid_d;
  logic               result_match_q, result_match_d;
  logic [TRY_W-1:0]   tries_left_q, tries_left_d;

  logic [OUT_W-1:0]   cmp_eq;
  logic               hit;
  logic               attempt_done;
  logic               attempt_miss;

  // idx_q is held at 0 outside CHECK, so one comparator serves both IDLE and CHECK.
  symbol_compare #(.WIDTH(WIDTH), .OUT_W(OUT_W)) u_cmp (
    .a  (guess_data),
    .b  (secret_q[idx_q]),
    .eq (cmp_eq)
  );

  assign hit = (cmp_eq == OUT_W'(EQ_TRUE));

  always_comb begin
    state_d        = state_q;
    secret_d       = secret_q;
    wr_ptr_d       = wr_ptr_q;
    idx_d          = idx_q;
    miss_d         = miss_q;
    sym_equal_d    = sym_equal_q;
    match_count_d  = match_count_q;
    result_valid_d = 1'b0;
    result_match_d = result_match_q;
    tries_left_d   = tries_left_q;
    attempt_done   = 1'b0;
    attempt_miss   = 1'b0;

    case (state_q)
      PROG: begin
        if (prog_valid) begin
          secret_d[wr_ptr_q] = prog_data;
          if (wr_ptr_q == LAST_IDX) begin
            wr_ptr_d = '0;
            state_d  = IDLE;
          end else begin
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
          end
        end
      end
      IDLE: begin
        if (prog_valid) begin
          secret_d[0]  = prog_data;
          tries_left_d = TRY_W'(MAX_TRIES);
          if (DEPTH == 1) begin
            wr_ptr_d = '0;
          end else begin
            wr_ptr_d = IDX_W'(1);
            state_d  = PROG;
          end
        end else if (guess_valid) begin
          sym_equal_d   = cmp_eq;
          match_count_d = CNT_W'(hit);
          miss_d        = !hit;
          if (DEPTH == 1) begin
            attempt_done = 1'b1;
            attempt_miss = !hit;
          end else begin
            idx_d   = IDX_W'(1);
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (clear) begin
          state_d       = IDLE;
          idx_d         = '0;
          match_count_d = '0;
          miss_d        = 1'b0;
        end else if (guess_valid) begin
          sym_equal_d   = cmp_eq;
          match_count_d = match_count_q + CNT_W'(hit);
          miss_d        = miss_q | !hit;
          if (idx_q == LAST_IDX) begin
            attempt_done = 1'b1;
            attempt_miss = miss_q | !hit;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: ;
    endcase

    if (attempt_done) begin
      result_valid_d = 1'b1;
      result_match_d = !attempt_miss;
      idx_d          = '0;
      if (!attempt_miss) begin
        tries_left_d = TRY_W'(MAX_TRIES);
        state_d      = IDLE;
      end else if (tries_left_q <= TRY_W'(1)) begin
        tries_left_d = '0;
        state_d      = LOCKED;
      end else begin
        tries_left_d = tries_left_q - TRY_W'(1);
        state_d      = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= PROG;
      for (int unsigned i = 0; i < DEPTH; i++) secret_q[i] <= '0;
      wr_ptr_q       <= '0;
      idx_q          <= '0;
      miss_q         <= 1'b0;
      sym_equal_q    <= '0;
      match_count_q  <= '0;
      result_valid_q <= 1'b0;
      result_match_q <= 1'b0;
      tries_left_q   <= TRY_W'(MAX_TRIES);
    end else begin
      state_q        <= state_d;
      secret_q       <= secret_d;
      wr_ptr_q       <= wr_ptr_d;
      idx_q          <= idx_d;
      miss_q         <= miss_d;
      sym_equal_q    <= sym_equal_d;
      match_count_q  <= match_count_d;
      result_valid_q <= result_valid_d;
      result_match_q <= result_match_d;
      tries_left_q   <= tries_left_d;
    end
  end

  assign locked       = (state_q == LOCKED);
  assign sym_equal    = locked ? OUT_W'(EQ_FALSE) : sym_equal_q;
  assign match_count  = match_count_q;
  assign result_valid = result_valid_q;
  assign result_match = result_match_q;
  assign tries_left   = tries_left_q;

endmodule
